// File: rtl/jtag_shift_master.sv
// JTAG shift master: turns RESET / TMS_SEQ / SCAN / SCAN_FLIP commands into TCK/TMS/TDI
// bit streams at a programmable TCK rate. Optional TRST output with macro JTAG_TRST_EN.
module jtag_shift_master #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned LEN_W = $clog2(DATA_W) + 1,
  localparam int unsigned IDX_W = $clog2(DATA_W)
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
`ifdef JTAG_TRST_EN
  ,
  output logic              trst_n
`endif
);

  typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StRsp} state_e;
  typedef enum logic [1:0] {OpReset, OpTmsSeq, OpScan, OpScanFlip} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               live_q;

  logic               accept;
  logic               cnt_done;
  logic               last_bit;
  logic [LEN_W-1:0]   eff_len;
  logic [IDX_W-1:0]   next_idx;
  op_e                cmd_op_e;

  // Returns {tms, tdi} for bit position idx of a command.
  function automatic logic [1:0] drive_bit(input op_e op, input logic bit_val,
                                           input logic [IDX_W-1:0] idx,
                                           input logic [LEN_W-1:0] len);
    logic tms_v;
    logic tdi_v;
    tms_v = 1'b0;
    tdi_v = 1'b0;
    unique case (op)
      OpReset:    tms_v = (idx < IDX_W'(5));
      OpTmsSeq:   tms_v = bit_val;
      OpScan:     tdi_v = bit_val;
      OpScanFlip: begin
        tdi_v = bit_val;
        tms_v = ({1'b0, idx} == len - LEN_W'(1));
      end
      default: ;
    endcase
    if (len == '0) begin
      tms_v = 1'b0;
      tdi_v = 1'b0;
    end
    return {tms_v, tdi_v};
  endfunction

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state_q == StIdle) && enable && live_q;
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_done  = (cnt_q == div_q);
  assign last_bit  = ({1'b0, bit_q} == len_q - LEN_W'(1));
  assign next_idx  = bit_q + IDX_W'(1);

  always_comb begin
    eff_len = cmd_len;
    if (cmd_op_e == OpReset) begin
      eff_len = LEN_W'(6);
    end else if (cmd_len > LEN_W'(DATA_W)) begin
      eff_len = LEN_W'(DATA_W);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    len_d   = len_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d             = cmd_op_e;
          // data_q holds the bits still to be driven; bit 0 goes out right now.
          data_d           = cmd_data >> 1;
          len_d            = eff_len;
          div_d            = cfg_div;
          cnt_d            = '0;
          bit_d            = '0;
          cap_d            = '0;
          tck_d            = 1'b0;
          {tms_d, tdi_d}   = drive_bit(cmd_op_e, cmd_data[0], '0, eff_len);
          state_d          = StShiftLo;
        end
      end
      StShiftLo: begin
        if (len_q == '0) begin
          tms_d   = 1'b0;
          tdi_d   = 1'b0;
          state_d = StRsp;
        end else if (cnt_done) begin
          cnt_d   = '0;
          tck_d   = 1'b1;
          if (op_q == OpScan || op_q == OpScanFlip) begin
            cap_d[bit_q] = tdo;
          end
          state_d = StShiftHi;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StShiftHi: begin
        if (cnt_done) begin
          cnt_d = '0;
          tck_d = 1'b0;
          if (last_bit) begin
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            state_d = StRsp;
          end else begin
            bit_d          = next_idx;
            data_d         = data_q >> 1;
            {tms_d, tdi_d} = drive_bit(op_q, data_q[0], next_idx, len_q);
            state_d        = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= OpReset;
      data_q  <= '0;
      len_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      cap_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      len_q   <= len_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      live_q  <= 1'b1;
    end
  end

`ifdef JTAG_TRST_EN
  logic trst_q;
  logic trst_d;

  // TRST tracks the TMS=1 periods of a RESET command and is released otherwise.
  always_comb begin
    trst_d = 1'b1;
    if ((state_d == StShiftLo || state_d == StShiftHi) && op_d == OpReset && tms_d) begin
      trst_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      trst_q <= 1'b0;
    end else begin
      trst_q <= trst_d;
    end
  end

  assign trst_n = trst_q;
`endif

  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = (state_q == StRsp);
  assign rsp_data  = cap_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/jtag_shift_master.md
JTAG_SHIFT_MASTER -- requirements
Module: jtag_shift_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the maximum bits per scan command and the command/response data width.
REQ-002 SHALL have parameter DIV_W, default 8, giving the TCK divider width.
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: when 0, no new command is accepted.
REQ-006 SHALL have port cfg_div, input, DIV_W bits: TCK half-period minus 1, in mclk cycles.
REQ-007 SHALL have port cmd_valid, input, 1 bit, and port cmd_ready, output, 1 bit: the command handshake.
REQ-008 SHALL have port cmd_op, input, 2 bits: 0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP.
REQ-009 SHALL have port cmd_len, input, $clog2(DATA_W)+1 bits: bit count.
REQ-010 SHALL have port cmd_data, input, DATA_W bits: TMS bits (TMS_SEQ) or TDI bits (SCAN*), LSB first.
REQ-011 SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the response handshake.
REQ-012 SHALL have port rsp_data, output, DATA_W bits: captured TDO, right-aligned.
REQ-013 SHALL have port busy, output, 1 bit: high from command accept until response acceptance.
REQ-014 SHALL have ports tck, tms and tdi, outputs, 1 bit each, and port tdo, input, 1 bit.

Function
REQ-015 SHALL have states IDLE, SHIFT_LO, SHIFT_HI and RSP.
REQ-016 SHALL assert cmd_ready only in IDLE with enable=1; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-017 SHALL latch cmd_op, cmd_data, cmd_len and cfg_div on accept; changes to these inputs after accept have no effect on that command.
REQ-018 SHALL clamp an effective length above DATA_W to DATA_W.
REQ-019 SHALL give RESET an effective length of 6: TMS=1 for 5 TCK periods, then TMS=0 for 1 period; cmd_len and cmd_data are ignored.
REQ-020 SHALL, on the accept edge, drive bit 0 onto tms (TMS_SEQ/RESET) or tdi (SCAN*) with tck=0, and enter SHIFT_LO.
REQ-021 SHALL raise tck after cfg_div+1 cycles in SHIFT_LO, and capture tdo into capture bit i on that same edge.
REQ-022 SHALL lower tck after cfg_div+1 cycles in SHIFT_HI and drive bit i+1 on that edge.
REQ-023 SHALL give TCK a period of exactly 2*(cfg_div+1) mclk cycles.
REQ-024 SHALL, during SCAN*, hold tms=0, except that SCAN_FLIP holds tms=1 for the whole final bit period.
REQ-025 SHALL, during TMS_SEQ/RESET, hold tdi=0.
REQ-026 SHALL, on the falling tck edge ending the last bit, drive tms=0 and tdi=0, assert rsp_valid and enter RSP.
REQ-027 SHALL give a latency from accept edge to rsp_valid of 2*len*(cfg_div+1) cycles.
REQ-028 SHALL complete a command with cmd_len=0 and op other than RESET with no TCK pulse, asserting rsp_valid on the edge after accept with rsp_data=0.
REQ-029 SHALL set rsp_data[i] to the tdo value captured for bit i, with bits at index len and above equal to 0.
REQ-030 SHALL return rsp_data=0 for TMS_SEQ and RESET.
REQ-031 SHALL hold rsp_valid and rsp_data stable until rsp_ready=1, then return to IDLE on the next edge.
REQ-032 SHALL NOT raise cmd_ready in the cycle rsp_valid&rsp_ready fires.
REQ-033 SHALL let an in-flight command finish normally when enable deasserts mid-command.
REQ-034 SHALL keep tck low whenever the state is IDLE or RSP.

Reset
REQ-035 SHALL, while reset_n=0, asynchronously force state=IDLE, tck=0, tms=0, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, and clear the bit and divider counters.
REQ-036 SHALL abort any in-flight command on reset with no response; cmd_ready may rise on the first edge after reset_n=1 when enable=1.

Configuration
REQ-037 SHALL, with macro JTAG_TRST_EN defined, add output trst_n, reset value 0, driven 0 for the 5 TMS=1 periods of a RESET command and 1 otherwise, released on the 5th falling tck edge.
REQ-038 SHALL, without JTAG_TRST_EN, not have port trst_n, and RESET shall use TMS only.

Verification
REQ-039 SHALL cover: cfg_div=1, RESET -> 6 tck pulses of period 4 cycles, tms=1,1,1,1,1,0; rsp_valid at accept+24; rsp_data=0.
REQ-040 SHALL cover: cfg_div=0, SCAN len=8 cmd_data=0xA5, TDO model echoing TDI delayed one bit -> tdi sequence 1,0,1,0,0,1,0,1; rsp_data=0x4A; tms=0 throughout; latency 16.
REQ-041 SHALL cover: SCAN_FLIP len=5 data=0x1F -> tms=1 only during the 5th bit period; rsp_data[31:5]=0.
REQ-042 SHALL cover: SCAN len=40 with DATA_W=32 -> exactly 32 tck pulses; SCAN len=0 -> no pulse, rsp_valid on the edge after accept.
REQ-043 SHALL cover: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, tck=0; deassert enable mid-scan -> command completes, next command not accepted.
REQ-044 SHALL cover: reset_n pulsed low during bit 3 of a len=16 scan -> all outputs 0 immediately, no rsp_valid; with JTAG_TRST_EN, trst_n=0 during reset and for RESET periods 1-5.
